dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Two-master arbiter for the single-port data RAM: 1024 x 32-bit words, synchronous read, one-cycle read latency.
- Master 0 is the CPU data port, reached through the address decode for region 0x0.
- Master 1 is a secondary engine, such as the life-game stepper or a DMA.
- Arbitration is per cycle and round-robin. Master 1 has a bounded burst lock, and each read response is routed back to the master that issued the read.

Parameters:
AW, 10, RAM word-address width
DW, 32, data width
MAX_LOCK, 16, max consecutive contested m1 grants under lock before m0 is forced through

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  CPU access request
m0_we  in  1  CPU write enable (qualified by m0_req)
m0_addr  in  AW  CPU word address
m0_wdata  in  DW  CPU write data
m0_gnt  out  1  CPU access accepted this cycle (combinational)
m0_stall  out  1  m0_req & ~m0_gnt
m0_rvalid  out  1  CPU read data valid
m0_rdata  out  DW  CPU read data
m1_req  in  1  engine access request
m1_lock  in  1  engine requests burst ownership
m1_we  in  1  engine write enable
m1_addr  in  AW  engine word address
m1_wdata  in  DW  engine write data
m1_gnt  out  1  engine access accepted this cycle
m1_rvalid  out  1  engine read data valid
m1_rdata  out  DW  engine read data
ram_addr  out  AW  to RAM
ram_we  out  1  to RAM
ram_data_in  out  DW  to RAM
ram_data_out  in  DW  from RAM, valid the cycle after a read address is presented

Behaviour:
- Reset (async, rst_n=0):
  - owner=IDLE, last_gnt=1 so m0 wins the first contest, lock_cnt=0.
  - m0_rvalid=m1_rvalid=0. Combinational outputs follow the idle rules below.
  - An in-flight read is dropped; no rvalid is issued after reset.
- Owner register, states IDLE/OWN0/OWN1: records which master was granted in the previous cycle. Updated every clock: gnt0 -> OWN0, gnt1 -> OWN1, neither -> IDLE.
- Grant decision (combinational, at most one gnt per cycle):
  - Only m0_req: gnt0.
  - Only m1_req: gnt1.
  - Both requesting, owner=OWN1, m1_lock=1, lock_cnt<MAX_LOCK: gnt1.
  - Both requesting otherwise: grant the master opposite last_gnt.
  - Neither requesting: no grant; ram_we=0, ram_addr=0, ram_data_in=0.
- RAM mux: ram_addr/ram_we/ram_data_in come from the granted master. ram_we = granted master's we.
- last_gnt: updated only on a grant (0 or 1); holds when idle.
- lock_cnt:
  - Increments on a contested gnt1 while owner=OWN1 and m1_lock=1, saturating at MAX_LOCK.
  - Clears on any gnt0, on m1_lock=0, or when m1_req=0.
  - When lock_cnt==MAX_LOCK and both request, m0 is granted. The count then clears, and m1 may reacquire the lock from the next cycle.
  - Uncontested m1 grants do not increment it.
- Read return:
  - m0_rvalid <= gnt0 & ~m0_we, and m1_rvalid <= gnt1 & ~m1_we, both registered.
  - mX_rdata = ram_data_out when mX_rvalid, else 0.
  - Latency: exactly 1 cycle from gnt to rvalid.
- Writes: complete in the grant cycle with no response. A read then a write to the same address in consecutive cycles returns the old data.
- A master must hold req/we/addr/wdata stable until it sees gnt. The arbiter does not latch requests. mX_stall is the CPU/engine hold signal.
- Simultaneous events:
  - Lock expiry coinciding with m1_lock deassert: m0 is granted either way.
  - A request withdrawn before grant is simply lost; no error.
- Address width: only AW bits are used. Upper-bit decode is done upstream.

Test Plan:
- Both masters idle after reset, then m0 read addr 0x005 (RAM holds 0xDEADBEEF) -> m0_gnt same cycle, m0_rvalid=1 and m0_rdata=0xDEADBEEF next cycle; m1_rvalid stays 0.
- m0 and m1 request continuously, lock=0, from reset -> grants alternate m0,m1,m0,m1; first contested grant goes to m0.
- m1 writes 0x11111111 to 0x010 while m0 reads 0x010 in the same cycle, m1_lock=0, last_gnt=0 -> m1 granted, m0_stall=1. Next cycle m0 is granted; the cycle after, m0_rdata=0x11111111.
- m1_lock=1 with both requesting continuously, MAX_LOCK=16 -> m1 granted 16 contested cycles after acquiring ownership, then m0 granted for one cycle, then m1 again.
- Async rst_n low mid-cycle after an m1 read grant, before rvalid -> m1_rvalid never asserts. After release, the first contest goes to m0.
- Back-to-back m1 reads at 0x3FF then 0x000 (wrap, uncontested) -> rvalid on consecutive cycles with matching data; lock_cnt stays 0.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-master round-robin arbiter for the single-port data RAM; m1 may hold a bounded burst lock.
// Grants are combinational. Read data returns one cycle later, steered to the issuing master.
module dram_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_stall,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW-1:0] ram_data_out
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_e;

  owner_e          owner_q, owner_d;
  logic            last_gnt_q, last_gnt_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            m0_rvalid_q, m0_rvalid_d;
  logic            m1_rvalid_q, m1_rvalid_d;
  logic            gnt0, gnt1, contested, lock_hold;

  always_comb begin
    contested = m0_req & m1_req;
    // m1 keeps the RAM only while it already owned it last cycle and the burst budget remains.
    lock_hold = contested && (owner_q == OWN1) && m1_lock && (lock_cnt_q < CW'(MAX_LOCK));
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (m0_req && !m1_req) begin
      gnt0 = 1'b1;
    end else if (m1_req && !m0_req) begin
      gnt1 = 1'b1;
    end else if (contested) begin
      if (lock_hold)       gnt1 = 1'b1;
      else if (last_gnt_q) gnt0 = 1'b1;
      else                 gnt1 = 1'b1;
    end

    ram_addr    = '0;
    ram_we      = 1'b0;
    ram_data_in = '0;
    if (gnt0) begin
      ram_addr    = m0_addr;
      ram_we      = m0_we;
      ram_data_in = m0_wdata;
    end else if (gnt1) begin
      ram_addr    = m1_addr;
      ram_we      = m1_we;
      ram_data_in = m1_wdata;
    end

    owner_d    = gnt0 ? OWN0 : (gnt1 ? OWN1 : IDLE);
    last_gnt_d = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : last_gnt_q);

    lock_cnt_d = lock_cnt_q;
    if (gnt0 || !m1_lock || !m1_req) begin
      lock_cnt_d = '0;
    end else if (gnt1 && contested && (owner_q == OWN1)) begin
      if (lock_cnt_q < CW'(MAX_LOCK)) lock_cnt_d = lock_cnt_q + CW'(1);
    end

    m0_rvalid_d = gnt0 & ~m0_we;
    m1_rvalid_d = gnt1 & ~m1_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      lock_cnt_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      lock_cnt_q  <= lock_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_stall  = m0_req & ~gnt0;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rvalid_q ? ram_data_out : '0;
  assign m1_rdata  = m1_rvalid_q ? ram_data_out : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed vector table, lock/reset sequences, randomized traffic vs. a reference model.
module tb_dram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MAX_LOCK = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m0_gnt, m0_stall, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_lock, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_data_in, ram_data_out;

  dram_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous read-first, one-cycle latency
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] iv(input int i);
    return 32'hC0DE0000 | i;
  endfunction

  // Reference model: winner of the previous cycle, last winner, length of the current locked run
  int own_m, last_m, run_m, pw;
  bit erv0, erv1;
  logic [31:0] erd0, erd1;
  logic [31:0] shadow [1024];

  task automatic model_reset();
    own_m = -1; last_m = 1; run_m = 0;
    erv0 = 0; erv1 = 0; erd0 = 0; erd1 = 0;
  endtask

  task automatic model_check();
    logic [AW-1:0] ea;
    logic          ew;
    logic [DW-1:0] ed;
    if (m0_req && !m1_req)      pw = 0;
    else if (!m0_req && m1_req) pw = 1;
    else if (m0_req && m1_req)  pw = (own_m == 1 && m1_lock && run_m < MAX_LOCK) ? 1 : 1 - last_m;
    else                        pw = -1;
    ea = (pw == 0) ? m0_addr : (pw == 1) ? m1_addr : '0;
    ew = (pw == 0) ? m0_we : (pw == 1) ? m1_we : 1'b0;
    ed = (pw == 0) ? m0_wdata : (pw == 1) ? m1_wdata : '0;
    chk("m0_gnt", m0_gnt, pw == 0);
    chk("m1_gnt", m1_gnt, pw == 1);
    chk("m0_stall", m0_stall, m0_req && pw != 0);
    chk("ram_addr", ram_addr, ea);
    chk("ram_we", ram_we, ew);
    chk("ram_data_in", ram_data_in, ed);
    chk("m0_rvalid", m0_rvalid, erv0);
    chk("m1_rvalid", m1_rvalid, erv1);
    chk("m0_rdata", m0_rdata, erv0 ? erd0 : 32'h0);
    chk("m1_rdata", m1_rdata, erv1 ? erd1 : 32'h0);
  endtask

  task automatic model_update();
    if (pw == 1 && m0_req && own_m == 1 && m1_lock) run_m = (run_m < MAX_LOCK) ? run_m + 1 : MAX_LOCK;
    else if (pw == 0 || !m1_lock || !m1_req)        run_m = 0;
    erv0 = (pw == 0) && !m0_we;
    erv1 = (pw == 1) && !m1_we;
    erd0 = shadow[m0_addr];
    erd1 = shadow[m1_addr];
    if (pw == 0 && m0_we) shadow[m0_addr] = m0_wdata;
    if (pw == 1 && m1_we) shadow[m1_addr] = m1_wdata;
    own_m = pw;
    if (pw >= 0) last_m = pw;
  endtask

  typedef struct {
    bit r0, w0; int a0; logic [31:0] d0;
    bit r1, l1, w1; int a1; logic [31:0] d1;
    bit g0, g1, st, rv0, rv1; logic [31:0] rd0, rd1;
  } vec_t;
  vec_t tbl[$];

  task automatic set_in(input bit r0, input bit w0, input int a0, input logic [31:0] d0,
                        input bit r1, input bit l1, input bit w1, input int a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = AW'(a0); m0_wdata = d0;
    m1_req = r1; m1_lock = l1; m1_we = w1; m1_addr = AW'(a1); m1_wdata = d1;
  endtask

  // Called at a falling edge: drive, settle, check against model
  task automatic apply(input bit r0, input bit w0, input int a0, input logic [31:0] d0,
                       input bit r1, input bit l1, input bit w1, input int a1, input logic [31:0] d1);
    set_in(r0, w0, a0, d0, r1, l1, w1, a1, d1);
    #1;
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst m0_rvalid", m0_rvalid, 1'b0);
    chk("rst m1_rvalid", m1_rvalid, 1'b0);
    chk("rst gnt", {m0_gnt, m1_gnt}, 2'b00);
    chk("rst ram_addr", ram_addr, '0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = iv(i);
      shadow[i] = iv(i);
    end
    mem[5] = 32'hDEADBEEF;
    shadow[5] = 32'hDEADBEEF;

    //            r0 w0 a0     d0            r1 l1 w1 a1     d1            g0 g1 st rv0 rv1 rd0           rd1
    tbl.push_back('{0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0, 0, 0, 0, 0,            0});
    tbl.push_back('{1, 0, 1,     0,            1, 0, 0, 2,     0,            1, 0, 0, 0, 0, 0,            0});
    tbl.push_back('{1, 0, 1,     0,            1, 0, 0, 2,     0,            0, 1, 1, 1, 0, iv(1),        0});
    tbl.push_back('{1, 0, 1,     0,            1, 0, 0, 2,     0,            1, 0, 0, 0, 1, 0,            iv(2)});
    tbl.push_back('{1, 0, 1,     0,            1, 0, 0, 2,     0,            0, 1, 1, 1, 0, iv(1),        0});
    tbl.push_back('{1, 0, 5,     0,            0, 0, 0, 0,     0,            1, 0, 0, 0, 1, 0,            iv(2)});
    tbl.push_back('{1, 0, 'h10,  0,            1, 0, 1, 'h10,  32'h11111111, 0, 1, 1, 1, 0, 32'hDEADBEEF, 0});
    tbl.push_back('{1, 0, 'h10,  0,            0, 0, 0, 0,     0,            1, 0, 0, 0, 0, 0,            0});
    tbl.push_back('{0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0, 0, 1, 0, 32'h11111111, 0});
    tbl.push_back('{0, 0, 0,     0,            1, 0, 0, 'h3FF, 0,            0, 1, 0, 0, 0, 0,            0});
    tbl.push_back('{0, 0, 0,     0,            1, 0, 0, 0,     0,            0, 1, 0, 0, 1, 0,            iv('h3FF)});
    tbl.push_back('{0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0, 0, 0, 1, 0,            iv(0)});
    tbl.push_back('{1, 0, 'h20,  0,            0, 0, 0, 0,     0,            1, 0, 0, 0, 0, 0,            0});
    tbl.push_back('{1, 1, 'h20,  32'h22222222, 0, 0, 0, 0,     0,            1, 0, 0, 1, 0, iv('h20),     0});
    tbl.push_back('{1, 0, 'h20,  0,            0, 0, 0, 0,     0,            1, 0, 0, 0, 0, 0,            0});
    tbl.push_back('{0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0, 0, 1, 0, 32'h22222222, 0});

    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      apply(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].l1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      chk($sformatf("v%0d gnt", i), {m0_gnt, m1_gnt}, {tbl[i].g0, tbl[i].g1});
      chk($sformatf("v%0d stall", i), m0_stall, tbl[i].st);
      chk($sformatf("v%0d rvalid", i), {m0_rvalid, m1_rvalid}, {tbl[i].rv0, tbl[i].rv1});
      chk($sformatf("v%0d m0_rdata", i), m0_rdata, tbl[i].rd0);
      chk($sformatf("v%0d m1_rdata", i), m1_rdata, tbl[i].rd1);
      advance();
    end

    // Burst lock from reset: m0 wins cycle 0, m1 takes 1 + 16 locked cycles, m0 forced through, repeat
    do_reset();
    for (int c = 0; c < 40; c++) begin
      apply(1, 0, c, 0, 1, 1, 0, 'h100 + c, 0);
      chk($sformatf("lock c%0d m0_gnt", c), m0_gnt, (c == 0 || c == 18 || c == 36));
      advance();
    end
    // Lock expiry coinciding with lock deassert still grants m0
    do_reset();
    for (int c = 0; c < 19; c++) begin
      apply(1, 0, 0, 0, 1, (c != 18), 0, 0, 0);
      chk($sformatf("expiry c%0d m0_gnt", c), m0_gnt, (c == 0 || c == 18));
      advance();
    end

    // Async reset after an m1 read grant, before its rvalid
    do_reset();
    apply(0, 0, 0, 0, 1, 0, 0, 7, 0);
    chk("mid-rst m1_gnt", m1_gnt, 1'b1);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid-rst m1_rvalid", m1_rvalid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post-rst m1_rvalid", m1_rvalid, 1'b0);
    advance();
    apply(1, 0, 3, 0, 1, 1, 0, 4, 0);
    chk("post-rst first contest m0", {m0_gnt, m1_gnt}, 2'b10);
    advance();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      apply(($urandom % 4) != 0, ($urandom % 3) == 0, $urandom_range(0, 15), $urandom,
            ($urandom % 4) != 0, ($urandom % 10) != 0, ($urandom % 3) == 0, $urandom_range(0, 15), $urandom);
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
